ifu_fetch: RTL and testbench

Instruction fetch initiator for the PDP-8 core. It owns the program counter and issues single-word reads on the IFU memory read interface (`ifu_rd_req` / `ifu_rd_addr` / `ifu_rd_data`). It captures the returned 12-bit word and holds it for the decode/execute stage under a valid/ack handshake. After each acknowledge it advances the PC by one, by two (skip), or to a loaded target (jump).

---
 rtl/pdp8_pkg.sv | 16 +
 rtl/ifu_pc_next.sv | 27 ++
 rtl/ifu_fetch.sv | 90 +++++++++
 tb/tb_ifu_fetch.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pdp8_pkg.sv
// Shared PDP-8 core definitions: bus widths, reset vector and the IFU state encoding.
package pdp8_pkg;

  localparam int ADDR_WIDTH = 12;
  localparam int DATA_WIDTH = 12;

  localparam logic [ADDR_WIDTH-1:0] START_PC_DEFAULT = 12'o0200;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } ifu_state_t;

endpackage

// File: rtl/ifu_pc_next.sv
// Combinational next-PC selector: jump beats skip beats sequential increment, modulo 2^12.
module ifu_pc_next
  import pdp8_pkg::*;
(
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] new_pc,
  input  logic                  skip,
  output logic [ADDR_WIDTH-1:0] next_pc
);

  logic [ADDR_WIDTH-1:0] w_pc_inc1;
  logic [ADDR_WIDTH-1:0] w_pc_inc2;

  assign w_pc_inc1 = pc + ADDR_WIDTH'(1);
  assign w_pc_inc2 = pc + ADDR_WIDTH'(2);

  always_comb begin
    next_pc = w_pc_inc1;
    if (load) begin
      next_pc = new_pc;
    end else if (skip) begin
      next_pc = w_pc_inc2;
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch initiator: owns the PC, issues single-word reads and holds each
// fetched word for the execute stage until acknowledged.
module ifu_fetch
  import pdp8_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] START_PC  = START_PC_DEFAULT,
  parameter int unsigned           CNT_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  run,
  output logic                  ifu_rd_req,
  output logic [ADDR_WIDTH-1:0] ifu_rd_addr,
  input  logic [DATA_WIDTH-1:0] ifu_rd_data,
  output logic                  instr_valid,
  output logic [DATA_WIDTH-1:0] instr_data,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  exec_ack,
  input  logic                  exec_load_pc,
  input  logic [ADDR_WIDTH-1:0] exec_new_pc,
  input  logic                  exec_skip,
  output logic [CNT_WIDTH-1:0]  fetch_count
);

  ifu_state_t            r_state;
  logic [ADDR_WIDTH-1:0] r_pc;
  logic                  r_instr_valid;
  logic [DATA_WIDTH-1:0] r_instr_data;
  logic [ADDR_WIDTH-1:0] r_instr_pc;
  logic [CNT_WIDTH-1:0]  r_fetch_count;
  logic [ADDR_WIDTH-1:0] w_pc_next;

  ifu_pc_next u_pc_next (
    .pc      (r_pc),
    .load    (exec_load_pc),
    .new_pc  (exec_new_pc),
    .skip    (exec_skip),
    .next_pc (w_pc_next)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_pc          <= START_PC;
      r_instr_valid <= 1'b0;
      r_instr_data  <= '0;
      r_instr_pc    <= '0;
      r_fetch_count <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (run) begin
            r_state <= REQ;
          end
        end
        REQ: begin
          r_state <= WAIT;
        end
        WAIT: begin
          r_instr_data  <= ifu_rd_data;
          r_instr_pc    <= r_pc;
          r_instr_valid <= 1'b1;
          if (r_fetch_count != '1) begin
            r_fetch_count <= r_fetch_count + CNT_WIDTH'(1);
          end
          r_state <= HOLD;
        end
        HOLD: begin
          // run is only consulted here so a fetch already in flight always completes
          if (exec_ack) begin
            r_instr_valid <= 1'b0;
            r_pc          <= w_pc_next;
            r_state       <= run ? REQ : IDLE;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign ifu_rd_req  = (r_state == REQ);
  assign ifu_rd_addr = r_pc;
  assign instr_valid = r_instr_valid;
  assign instr_data  = r_instr_data;
  assign instr_pc    = r_instr_pc;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: stimulus queues expected requests and instructions,
// a monitor pops and compares them as the DUT presents them.
module tb_ifu_fetch;
  import pdp8_pkg::*;

  logic                  clk;
  logic                  reset_n;
  logic                  run;
  logic                  ifu_rd_req;
  logic [ADDR_WIDTH-1:0] ifu_rd_addr;
  logic [DATA_WIDTH-1:0] ifu_rd_data;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  exec_ack;
  logic                  exec_load_pc;
  logic [ADDR_WIDTH-1:0] exec_new_pc;
  logic                  exec_skip;
  logic [15:0]           fetch_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [11:0] exp_req[$];
  logic [23:0] exp_instr[$];
  int          last_req_cyc = -1;
  int          expect_gap = 0;
  logic        prev_valid = 1'b0;

  ifu_fetch #(
    .START_PC  (12'o0200),
    .CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .run          (run),
    .ifu_rd_req   (ifu_rd_req),
    .ifu_rd_addr  (ifu_rd_addr),
    .ifu_rd_data  (ifu_rd_data),
    .instr_valid  (instr_valid),
    .instr_data   (instr_data),
    .instr_pc     (instr_pc),
    .exec_ack     (exec_ack),
    .exec_load_pc (exec_load_pc),
    .exec_new_pc  (exec_new_pc),
    .exec_skip    (exec_skip),
    .fetch_count  (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory returns addr + 7000 (octal), registered one cycle after the request.
  always @(posedge clk) begin
    if (ifu_rd_req) ifu_rd_data <= ifu_rd_addr + 12'o7000;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0o expected %0o", nm, act, exp);
    end
  endtask

  // Monitor: requests and newly valid instructions are matched against the queues.
  always @(negedge clk) begin
    if (reset_n && ifu_rd_req) begin
      if (exp_req.size() == 0) begin
        chk("unexpected_req", {20'd0, ifu_rd_addr}, 32'hFFFF_FFFF);
      end else begin
        chk("req_addr", {20'd0, ifu_rd_addr}, {20'd0, exp_req.pop_front()});
      end
      if (expect_gap != 0 && last_req_cyc >= 0)
        chk("req_spacing", cyc - last_req_cyc, expect_gap);
      last_req_cyc = cyc;
    end
    if (instr_valid && !prev_valid) begin
      if (exp_instr.size() == 0) begin
        chk("unexpected_valid", {8'd0, instr_data, instr_pc}, 32'hFFFF_FFFF);
      end else begin
        chk("instr_data_pc", {8'd0, instr_data, instr_pc}, {8'd0, exp_instr.pop_front()});
      end
      chk("valid_latency", cyc - last_req_cyc, 2);
    end
    prev_valid = instr_valid;
  end

  task automatic wait_valid();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (instr_valid) return;
    end
    chk("timeout_valid", 0, 1);
  endtask

  // Called at a negedge inside HOLD; ack lasts one cycle.
  task automatic ack(input logic ld, input logic sk, input logic [11:0] np);
    exec_ack = 1'b1; exec_load_pc = ld; exec_skip = sk; exec_new_pc = np;
    @(posedge clk); #1;
    exec_ack = 1'b0; exec_load_pc = 1'b0; exec_skip = 1'b0; exec_new_pc = 12'o1234;
  endtask

  initial begin
    reset_n = 1'b0; run = 1'b0; exec_ack = 1'b0; exec_load_pc = 1'b0;
    exec_skip = 1'b0; exec_new_pc = 12'o0; ifu_rd_data = 12'o0;
    repeat (3) @(negedge clk);
    chk("rst_valid", {31'd0, instr_valid}, 0);
    chk("rst_addr", {20'd0, ifu_rd_addr}, 12'o0200);
    chk("rst_count", {16'd0, fetch_count}, 0);
    chk("rst_req", {31'd0, ifu_rd_req}, 0);
    reset_n = 1'b1;
    @(negedge clk);

    // Start-up and sequential fetches, ack in the first HOLD cycle.
    exp_req.push_back(12'o0200); exp_instr.push_back({12'o7200, 12'o0200});
    exp_req.push_back(12'o0201); exp_instr.push_back({12'o7201, 12'o0201});
    exp_req.push_back(12'o0202); exp_instr.push_back({12'o7202, 12'o0202});
    run = 1'b1;
    wait_valid();
    chk("count_first", {16'd0, fetch_count}, 1);
    expect_gap = 3;
    ack(0, 0, 0);
    wait_valid();
    ack(0, 0, 0);
    wait_valid();
    expect_gap = 0;
    chk("count_three", {16'd0, fetch_count}, 3);

    // Backpressure: outputs hold, no further requests (monitor flags any).
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", {31'd0, instr_valid}, 1);
      chk("bp_data", {20'd0, instr_data}, 12'o7202);
      chk("bp_addr", {20'd0, ifu_rd_addr}, 12'o0202);
    end

    // Jump to 7776, skip wraps to 0000.
    exp_req.push_back(12'o7776); exp_instr.push_back({12'o6776, 12'o7776});
    ack(1, 0, 12'o7776);
    wait_valid();
    exp_req.push_back(12'o0000); exp_instr.push_back({12'o7000, 12'o0000});
    ack(0, 1, 0);
    wait_valid();
    // Jump to 7777, plain increment wraps to 0000.
    exp_req.push_back(12'o7777); exp_instr.push_back({12'o6777, 12'o7777});
    ack(1, 0, 12'o7777);
    wait_valid();
    exp_req.push_back(12'o0000); exp_instr.push_back({12'o7000, 12'o0000});
    ack(0, 0, 0);
    wait_valid();
    // Load beats skip.
    exp_req.push_back(12'o4000); exp_instr.push_back({12'o3000, 12'o4000});
    ack(1, 1, 12'o4000);
    wait_valid();
    chk("count_eight", {16'd0, fetch_count}, 8);

    // run=0 at ack parks the FSM.
    run = 1'b0;
    ack(0, 0, 0);
    repeat (6) @(negedge clk);
    chk("park_valid", {31'd0, instr_valid}, 0);
    chk("park_addr", {20'd0, ifu_rd_addr}, 12'o4001);

    // Restart, then reset while in WAIT.
    exp_req.push_back(12'o4001);
    run = 1'b1;
    begin : wait_req
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (ifu_rd_req) disable wait_req;
      end
      chk("timeout_req", 0, 1);
    end
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, instr_valid}, 0);
    chk("mid_rst_addr", {20'd0, ifu_rd_addr}, 12'o0200);
    chk("mid_rst_count", {16'd0, fetch_count}, 0);
    chk("mid_rst_data_pc", {8'd0, instr_data, instr_pc}, 0);
    chk("mid_rst_req", {31'd0, ifu_rd_req}, 0);
    @(negedge clk);
    chk("mid_rst_no_valid", {31'd0, instr_valid}, 0);
    exp_req.push_back(12'o0200); exp_instr.push_back({12'o7200, 12'o0200});
    reset_n = 1'b1;
    wait_valid();
    chk("post_rst_count", {16'd0, fetch_count}, 1);
    run = 1'b0;
    ack(0, 0, 0);
    repeat (5) @(negedge clk);
    chk("req_queue_empty", exp_req.size(), 0);
    chk("instr_queue_empty", exp_instr.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
